// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI mode-0 master for 32-bit register-access frames
//
// Purpose: accepts single read/write requests from a local host port and
// emits one frame {cmd[15:0], data[15:0]} MSB first on spi_sclk/spi_mosi/
// spi_cs_n. Data-phase MISO bits of a read are captured into rdata at done.
//
// Ports:
//   clk, rst_btn            system clock, synchronous active-high reset
//   start, rw, addr, wdata  request strobe and fields (latched on accept)
//   busy, done, rdata       status, one-cycle end pulse, captured read data
//   spi_sclk, spi_mosi,     SPI bus (sclk idles low, cs_n active low)
//   spi_cs_n, spi_miso
//   loopback                data-phase capture from internal MOSI
//
// Optional feature macro: SPI_MASTER_LOOPBACK_EN. When undefined the
// loopback port is present but has no effect.

module spi_master_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst_btn,
    input  logic        start,
    input  logic        rw,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    input  logic        spi_miso,
    input  logic        loopback
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam int CNT_W = 16;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [5:0]         bit_q;
    logic [31:0]        shift_q;
    logic [15:0]        cap_q;
    logic [15:0]        rdata_q;
    logic               rw_q;
    logic               sclk_q;
    logic               mosi_q;
    logic               cs_n_q;
    logic               busy_q;
    logic               done_q;

    // Frame assembled from the live request inputs; only loaded on accept.
    logic [31:0]        frame_d;
    logic               sample_d;
    logic               rdata_upd_d;

    assign frame_d = {5'b0, addr, 1'b0, rw, 1'b0, (rw ? 16'h0000 : wdata)};

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_q;
    // Loopback takes the bit currently driven on MOSI, so a read returns 0
    // and a write returns its own wdata.
    assign sample_d    = lb_q ? mosi_q : spi_miso;
    assign rdata_upd_d = rw_q | lb_q;
`else
    logic loopback_unused;
    assign loopback_unused = loopback;
    assign sample_d        = spi_miso;
    assign rdata_upd_d     = rw_q;
`endif

    always_ff @(posedge clk) begin
        if (rst_btn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q <= frame_d;
                        mosi_q  <= frame_d[31];
                        rw_q    <= rw;
`ifdef SPI_MASTER_LOOPBACK_EN
                        lb_q    <= loopback;
`endif
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_W'(CS_SETUP - 1);
                        state_q <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= CNT_W'(CLK_DIV - 1);
                        bit_q   <= '0;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        cnt_q <= CNT_W'(CLK_DIV - 1);
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // Last clk of the high half: latest possible sample
                            // point, giving the slave's synchronizer time.
                            if (bit_q[4]) begin
                                cap_q <= {cap_q[14:0], sample_d};
                            end
                            sclk_q <= 1'b0;
                            if (bit_q == 6'd31) begin
                                mosi_q  <= 1'b0;
                                cnt_q   <= CNT_W'(CS_HOLD - 1);
                                state_q <= HOLD;
                            end else begin
                                bit_q   <= bit_q + 1'b1;
                                shift_q <= {shift_q[30:0], 1'b0};
                                mosi_q  <= shift_q[30];
                            end
                        end
                    end
                end

                HOLD: begin
                    if (cnt_q == '0) begin
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        if (rdata_upd_d) begin
                            rdata_q <= cap_q;
                        end
                        cnt_q   <= CNT_W'(CS_GAP - 1);
                        state_q <= GAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                GAP: begin
                    if (cnt_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - self-checking bench for spi_master_ctrl

module tb_spi_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_btn;
    logic        start;
    logic        rw;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_miso;
    logic        loopback;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_master_ctrl dut (
        .clk      (clk),
        .rst_btn  (rst_btn),
        .start    (start),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_cs_n (spi_cs_n),
        .spi_miso (spi_miso),
        .loopback (loopback)
    );

    // Slave model: register file, samples MOSI on SCLK rise, drives MISO
    // a few clocks after each SCLK fall.
    logic [15:0] mem [0:255];
    logic        sclk_d     = 1'b0;
    logic        cs_d       = 1'b1;
    int          rise_cnt   = 0;
    int          fall_cnt   = 0;
    logic [31:0] rx         = 32'h0;
    logic [31:0] last_frame = 32'h0;
    logic [15:0] slave_val  = 16'h0;
    logic        want       = 1'b0;
    logic [1:0]  dly        = 2'b0;

    assign spi_miso = dly[1];

    always @(posedge clk) begin
        sclk_d <= spi_sclk;
        cs_d   <= spi_cs_n;
        dly    <= {dly[0], want};
        if (spi_cs_n) begin
            rise_cnt <= 0;
            fall_cnt <= 0;
            want     <= 1'b0;
            if (!cs_d && rise_cnt == 32) begin
                last_frame <= rx;
                if (!rx[17]) mem[rx[26:19]] <= rx[15:0];
            end
        end else begin
            if (!sclk_d && spi_sclk) begin
                rx       <= {rx[30:0], spi_mosi};
                rise_cnt <= rise_cnt + 1;
                if (rise_cnt == 15) slave_val <= mem[rx[9:2]];
            end
            if (sclk_d && !spi_sclk) begin
                fall_cnt <= fall_cnt + 1;
                if (fall_cnt >= 15 && fall_cnt <= 30) want <= slave_val[4'(30 - fall_cnt)];
                else want <= 1'b0;
            end
        end
    end

    task automatic run_frame(input logic r, input logic [7:0] a, input logic [15:0] d,
                             output int lat, output int cslow, output int ndone);
        lat = -1; cslow = 0; ndone = 0;
        @(negedge clk);
        rw = r; addr = a; wdata = d; start = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (!spi_cs_n) cslow++;
            if (done) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            if (lat > 0 && !busy) break;
        end
        checks++;
        if (lat < 0 || busy) begin
            failures++;
            $display("FAIL frame_timeout: lat=%0d busy=%b required done then idle", lat, busy);
        end
    endtask

    task automatic test_reset();
        rst_btn = 1'b1; start = 1'b0; rw = 1'b0; addr = 8'h0; wdata = 16'h0; loopback = 1'b0;
        repeat (3) @(negedge clk);
        rst_btn = 1'b0;
        @(negedge clk);
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk: got %b want 0", spi_sclk); end
        checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    endtask

    task automatic test_write();
        int lat, cslow, nd;
        run_frame(1'b0, 8'h05, 16'hAAAA, lat, cslow, nd);
        checks++; if (lat !== 137) begin failures++; $display("FAIL write_latency: got %0d want 137", lat); end
        checks++; if (cslow !== 136) begin failures++; $display("FAIL write_cs_low: got %0d want 136", cslow); end
        checks++; if (nd !== 1) begin failures++; $display("FAIL write_done_count: got %0d want 1", nd); end
        checks++; if (last_frame !== 32'h0028AAAA) begin failures++; $display("FAIL write_mosi: got %h want 0028aaaa", last_frame); end
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL write_rdata: got %h want 0000", rdata); end
    endtask

    task automatic test_read();
        int lat, cslow, nd;
        run_frame(1'b0, 8'h42, 16'h1234, lat, cslow, nd);
        checks++; if (last_frame !== 32'h02101234) begin failures++; $display("FAIL write42_mosi: got %h want 02101234", last_frame); end
        run_frame(1'b1, 8'h05, 16'hFFFF, lat, cslow, nd);
        checks++; if (rdata !== 16'hAAAA) begin failures++; $display("FAIL read05_rdata: got %h want aaaa", rdata); end
        checks++; if (last_frame !== 32'h002A0000) begin failures++; $display("FAIL read05_mosi: got %h want 002a0000", last_frame); end
        run_frame(1'b1, 8'h42, 16'h5555, lat, cslow, nd);
        checks++; if (rdata !== 16'h1234) begin failures++; $display("FAIL read42_rdata: got %h want 1234", rdata); end
        checks++; if (last_frame !== 32'h02120000) begin failures++; $display("FAIL read42_mosi: got %h want 02120000", last_frame); end
        checks++; if (lat !== 137) begin failures++; $display("FAIL read_latency: got %0d want 137", lat); end
    endtask

    task automatic test_back_to_back();
        int nd = 0, falls = 0, rise_at = -1, fall2_at = -1;
        logic prev_cs = 1'b1;
        @(negedge clk);
        rw = 1'b0; addr = 8'h11; wdata = 16'h0F0F; start = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k <= 141 && done) nd++;
            if (prev_cs && !spi_cs_n) begin
                falls++;
                if (falls == 1 && k != 1) begin end
                if (rise_at >= 0 && fall2_at < 0) fall2_at = k;
            end
            if (!prev_cs && spi_cs_n && rise_at < 0) rise_at = k;
            prev_cs = spi_cs_n;
            if (fall2_at >= 0) begin
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        checks++; if (nd !== 1) begin failures++; $display("FAIL b2b_done_count: got %0d want 1", nd); end
        checks++; if (rise_at !== 137) begin failures++; $display("FAIL b2b_cs_rise: got %0d want 137", rise_at); end
        checks++; if (fall2_at !== 142) begin failures++; $display("FAIL b2b_next_fall: got %0d want 142", fall2_at); end
        for (int k = 0; k < 400 && busy; k++) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drain: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_midframe();
        int lat, cslow, nd, seen_done = 0;
        @(negedge clk);
        rw = 1'b1; addr = 8'h42; wdata = 16'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 400 && rise_cnt < 11; k++) @(negedge clk);
        rst_btn = 1'b1;
        @(negedge clk);
        rst_btn = 1'b0;
        checks++; if (spi_cs_n !== 1'b1) begin failures++; $display("FAIL abort_cs_n: got %b want 1", spi_cs_n); end
        checks++; if (spi_sclk !== 1'b0) begin failures++; $display("FAIL abort_sclk: got %b want 0", spi_sclk); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL abort_rdata: got %h want 0000", rdata); end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++; if (seen_done !== 0) begin failures++; $display("FAIL abort_no_done: got %0d pulses want 0", seen_done); end
        run_frame(1'b1, 8'h42, 16'h0, lat, cslow, nd);
        checks++; if (rdata !== 16'h1234) begin failures++; $display("FAIL after_abort_rdata: got %h want 1234", rdata); end
        checks++; if (lat !== 137) begin failures++; $display("FAIL after_abort_latency: got %0d want 137", lat); end
    endtask

    task automatic test_loopback();
        int lat, cslow, nd;
        logic [15:0] exp_rdata;
`ifdef SPI_MASTER_LOOPBACK_EN
        exp_rdata = 16'hC3A5;
`else
        exp_rdata = 16'h1234;
`endif
        loopback = 1'b1;
        run_frame(1'b0, 8'h10, 16'hC3A5, lat, cslow, nd);
        loopback = 1'b0;
        checks++; if (rdata !== exp_rdata) begin failures++; $display("FAIL loopback_rdata: got %h want %h", rdata, exp_rdata); end
        checks++; if (last_frame !== 32'h0080C3A5) begin failures++; $display("FAIL loopback_mosi: got %h want 0080c3a5", last_frame); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_midframe();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
